// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared MDU types, default sizing and op decode helpers
package mdu_pkg;
  localparam int MDU_WIDTH_DEF   = 32;
  localparam int MDU_MUL_LAT_DEF = 2;

  typedef enum logic [2:0] {
    OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_DIV, OP_DIVU
  } mdu_op_t;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} mdu_state_t;

  typedef enum logic [1:0] {D_IDLE, D_SETUP, D_ITER, D_FIX} div_phase_t;

  // Anything not recognised below decodes as a plain unsigned multiply.
  function automatic logic op_is_div(mdu_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_mul_signed(mdu_op_t op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic op_mul_add(mdu_op_t op);
    return (op == OP_MADD) || (op == OP_MADDU);
  endfunction

  function automatic logic op_mul_sub(mdu_op_t op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction
endpackage

// File: rtl/mdu_div_iter.sv
// rtl/mdu_div_iter.sv - restoring radix-2 divider, one quotient bit per cycle
module mdu_div_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH) + 1;

  div_phase_t       phase, phase_nxt;
  logic [WIDTH-1:0] a_q, b_q, dvs_q, quo_q, rem_q;
  logic             sgn_q, neg_quo_q, neg_rem_q, dz_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             trial_neg;

  // The dividend is shifted out of quo_q while quotient bits shift in.
  assign shifted   = {rem_q, quo_q[WIDTH-1]};
  assign trial_neg = shifted < {1'b0, dvs_q};
  assign diff      = shifted[WIDTH-1:0] - dvs_q;

  always_ff @(posedge clk) begin
    if (rst) phase <= D_IDLE;
    else     phase <= phase_nxt;
  end

  always_comb begin
    phase_nxt = phase;
    case (phase)
      D_IDLE:  if (start) phase_nxt = D_SETUP;
      D_SETUP: phase_nxt = (b_q == '0) ? D_FIX : D_ITER;
      D_ITER:  if (cnt_q == CW'(1)) phase_nxt = D_FIX;
      default: phase_nxt = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      dvs_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      sgn_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      case (phase)
        D_IDLE: if (start) begin
          a_q   <= a;
          b_q   <= b;
          sgn_q <= is_signed;
        end
        D_SETUP: begin
          quo_q     <= (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
          dvs_q     <= (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
          rem_q     <= '0;
          cnt_q     <= CW'(WIDTH);
          neg_quo_q <= sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_rem_q <= sgn_q && a_q[WIDTH-1];
          dz_q      <= (b_q == '0);
        end
        D_ITER: begin
          rem_q <= trial_neg ? shifted[WIDTH-1:0] : diff;
          quo_q <= {quo_q[WIDTH-2:0], ~trial_neg};
          cnt_q <= cnt_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Sign fix-up happens combinationally during the FIX cycle.
  always_comb begin
    done      = (phase == D_FIX);
    div_zero  = dz_q;
    quotient  = dz_q ? '1  : (neg_quo_q ? -quo_q : quo_q);
    remainder = dz_q ? a_q : (neg_rem_q ? -rem_q : rem_q);
  end
endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - multiply/divide unit: pipelined multiplier, iterative divider
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH   = MDU_WIDTH_DEF,
  parameter int MUL_LAT = MDU_MUL_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  mdu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  localparam int PW = 2 * WIDTH;

  mdu_state_t       state, state_nxt;
  logic             accept, accept_div;
  mdu_op_t          op_q;
  logic [WIDTH-1:0] a_q, b_q, abs_a, abs_b;
  logic [PW-1:0]    acc_q, prod_mag, prod, mul_res;
  logic             mul_neg, mul_start, mul_last;
  logic [MUL_LAT-1:0] pipe_vld;
  logic [PW-1:0]    pipe_data [MUL_LAT];
  logic             div_done, div_dz;
  logic [WIDTH-1:0] div_quo, div_rem;

  assign accept     = in_valid && (state == S_IDLE) && !flush;
  assign accept_div = accept && op_is_div(op);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (accept) state_nxt = op_is_div(op) ? S_DIV : S_MUL;
        S_MUL:   if (mul_last) state_nxt = S_DONE;
        S_DIV:   if (div_done) state_nxt = S_DONE;
        S_DONE:  if (out_ready) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= OP_MULTU;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (accept) begin
      op_q  <= op;
      a_q   <= a;
      b_q   <= b;
      acc_q <= {hi_in, lo_in};
    end
  end

  // Sign-magnitude multiply on the latched operands feeds the first stage.
  assign mul_neg  = op_mul_signed(op_q) && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
  assign abs_a    = (op_mul_signed(op_q) && a_q[WIDTH-1]) ? -a_q : a_q;
  assign abs_b    = (op_mul_signed(op_q) && b_q[WIDTH-1]) ? -b_q : b_q;
  assign prod_mag = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
  assign prod     = mul_neg ? -prod_mag : prod_mag;
  assign mul_last = pipe_vld[MUL_LAT-1];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mul_start <= 1'b0;
      pipe_vld  <= '0;
    end else begin
      mul_start   <= accept && !op_is_div(op);
      pipe_vld[0] <= mul_start;
      for (int i = 1; i < MUL_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_data[0] <= prod;
    for (int i = 1; i < MUL_LAT; i++) pipe_data[i] <= pipe_data[i-1];
  end

  always_comb begin
    mul_res = pipe_data[MUL_LAT-1];
    if (op_mul_add(op_q))      mul_res = acc_q + pipe_data[MUL_LAT-1];
    else if (op_mul_sub(op_q)) mul_res = acc_q - pipe_data[MUL_LAT-1];
  end

  // Flush doubles as a divider reset so an aborted division leaves no state.
  mdu_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst || flush),
    .start     (accept_div),
    .a         (a),
    .b         (b),
    .is_signed (op == OP_DIV),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem),
    .div_zero  (div_dz)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else if (!flush) begin
      if (state == S_MUL && mul_last) begin
        {hi, lo} <= mul_res;
        div_zero <= 1'b0;
      end else if (state == S_DIV && div_done) begin
        hi       <= div_rem;
        lo       <= div_quo;
        div_zero <= div_dz;
      end
    end
  end
endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - scoreboard bench for mdu_iter with a wide-arithmetic model
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int W  = 32;
  localparam int ML = 2;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          acc_cyc;
    mdu_op_t     op;
  } exp_t;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready, div_zero;
  mdu_op_t     op;
  logic [31:0] a, b, hi_in, lo_in, hi, lo;

  logic        in_valid16, in_ready16, out_valid16, div_zero16;
  mdu_op_t     op16;
  logic [15:0] a16, b16, hi16, lo16;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   hold_low = 0;
  exp_t sb[$];

  mdu_iter #(.WIDTH(W), .MUL_LAT(ML)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .hi_in(hi_in), .lo_in(lo_in), .out_valid(out_valid),
    .out_ready(out_ready), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  mdu_iter #(.WIDTH(16), .MUL_LAT(ML)) u_dut16 (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(in_valid16), .in_ready(in_ready16),
    .op(op16), .a(a16), .b(b16), .hi_in(16'h0), .lo_in(16'h0), .out_valid(out_valid16),
    .out_ready(1'b1), .hi(hi16), .lo(lo16), .div_zero(div_zero16)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Results follow arithmetic definitions on 64-bit integers, not the hardware algorithm.
  function automatic exp_t model(mdu_op_t o, logic [31:0] ma, mb, mh, ml);
    exp_t        e;
    logic [63:0] p, acc;
    longint      sa, sbv, q, r;
    e.op = o;
    e.dz = 1'b0;
    e.acc_cyc = 0;
    acc = {mh, ml};
    if (o == OP_DIV || o == OP_DIVU) begin
      e.lat = W + 2;
      if (mb == 0) begin
        e.lo = '1;
        e.hi = ma;
        e.dz = 1'b1;
        e.lat = 2;
      end else if (o == OP_DIV) begin
        sa  = longint'($signed(ma));
        sbv = longint'($signed(mb));
        q = sa / sbv;
        r = sa % sbv;
        e.lo = q[31:0];
        e.hi = r[31:0];
      end else begin
        e.lo = ma / mb;
        e.hi = ma % mb;
      end
    end else begin
      e.lat = ML + 1;
      if (o == OP_MULT || o == OP_MADD || o == OP_MSUB)
        p = longint'($signed(ma)) * longint'($signed(mb));
      else
        p = {32'h0, ma} * {32'h0, mb};
      if (o == OP_MADD || o == OP_MADDU) p = acc + p;
      if (o == OP_MSUB || o == OP_MSUBU) p = acc - p;
      {e.hi, e.lo} = p;
    end
    return e;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input mdu_op_t o, input logic [31:0] ia, ib, ih, il);
    exp_t e;
    int   waited = 0;
    @(posedge clk); #1;
    in_valid = 1; op = o; a = ia; b = ib; hi_in = ih; lo_in = il;
    forever begin
      @(negedge clk);
      if (in_ready && !flush && !rst) break;
      if (++waited > 300) begin
        timeout("issue_ready");
        @(posedge clk); #1;
        in_valid = 0;
        return;
      end
    end
    e = model(o, ia, ib, ih, il);
    e.acc_cyc = cyc + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    int waited = 0;
    forever begin
      @(negedge clk);
      if (sb.size() == 0 && in_ready) break;
      if (++waited > 500) begin
        timeout("drain");
        sb.delete();
        break;
      end
    end
  endtask

  // Accept a DIVU, then abort it with flush or rst during iteration 10.
  task automatic abort_test(input bit use_rst);
    int vcnt = 0;
    @(posedge clk); #1;
    in_valid = 1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    chk("abort_accept_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 0;
    repeat (10) @(posedge clk);
    #1;
    if (use_rst) rst = 1; else flush = 1;
    @(posedge clk); #1;
    rst = 0; flush = 0;
    @(negedge clk);
    chk(use_rst ? "rst_in_ready" : "flush_in_ready", 64'(in_ready), 64'd1);
    chk(use_rst ? "rst_out_valid" : "flush_out_valid", 64'(out_valid), 64'd0);
    if (use_rst) begin
      chk("rst_mid_hi", 64'(hi), 64'd0);
      chk("rst_mid_lo", 64'(lo), 64'd0);
      chk("rst_mid_dz", 64'(div_zero), 64'd0);
    end
    repeat (40) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    chk("abort_no_result", 64'(vcnt), 64'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares every presented result against the scoreboard head.
  initial begin
    exp_t        e;
    bit          seen = 0, stab = 0;
    logic [31:0] p_hi, p_lo;
    logic        p_dz;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 0;
        stab = 0;
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          if (!seen) timeout("spurious_out_valid");
          seen = 1;
        end else begin
          e = sb[0];
          if (!seen) chk($sformatf("latency_%s", e.op.name()), 64'(cyc - e.acc_cyc), 64'(e.lat));
          seen = 1;
          if (stab) begin
            chk("stable_hi", 64'(hi), 64'(p_hi));
            chk("stable_lo", 64'(lo), 64'(p_lo));
            chk("stable_dz", 64'(div_zero), 64'(p_dz));
          end
          chk("done_in_ready", 64'(in_ready), 64'd0);
          if (out_ready) begin
            chk($sformatf("hi_%s", e.op.name()), 64'(hi), 64'(e.hi));
            chk($sformatf("lo_%s", e.op.name()), 64'(lo), 64'(e.lo));
            chk($sformatf("dz_%s", e.op.name()), 64'(div_zero), 64'(e.dz));
            void'(sb.pop_front());
            seen = 0;
            stab = 0;
          end else begin
            p_hi = hi; p_lo = lo; p_dz = div_zero;
            stab = 1;
          end
        end
      end
    end
  end

  initial begin
    int waited;
    int p;
    rst = 1; flush = 0; in_valid = 0; op = OP_MULTU; a = 0; b = 0; hi_in = 0; lo_in = 0;
    in_valid16 = 0; op16 = OP_MULTU; a16 = 0; b16 = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_dz", 64'(div_zero), 64'd0);
    @(posedge clk); #1;
    rst = 0;

    issue(OP_MULT,  32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0);
    issue(OP_MSUBU, 32'd2, 32'd3, 32'h0, 32'd5);
    issue(OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0);
    issue(OP_DIVU,  32'd10, 32'd0, 32'h0, 32'h0);
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0);
    issue(OP_MADD,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();

    hold_low = 1;
    issue(OP_DIVU, 32'd100, 32'd7, 32'h0, 32'h0);
    waited = 0;
    while (!out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!out_valid) timeout("hold_wait_valid");
    repeat (5) begin
      @(negedge clk);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
    end
    hold_low = 0;
    drain();

    abort_test(0);
    issue(OP_MULTU, 32'd6, 32'd7, 32'h0, 32'h0);
    drain();
    abort_test(1);
    issue(OP_MULTU, 32'd6, 32'd7, 32'h0, 32'h0);
    drain();

    for (int n = 0; n < 150; n++) begin
      mdu_op_t o;
      o = mdu_op_t'($urandom_range(0, 7));
      issue(o, rnd_val(), rnd_val(), $urandom, $urandom);
    end
    drain();

    @(posedge clk); #1;
    in_valid16 = 1; op16 = OP_DIV; a16 = 16'hFFF9; b16 = 16'd2;
    @(negedge clk);
    chk("w16_in_ready", 64'(in_ready16), 64'd1);
    @(posedge clk); #1;
    in_valid16 = 0;
    p = cyc;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!out_valid16 && waited < 100);
    if (!out_valid16) timeout("w16_wait_valid");
    else begin
      chk("w16_latency", 64'(cyc - p), 64'd18);
      chk("w16_lo", 64'(lo16), 64'hFFFD);
      chk("w16_hi", 64'(hi16), 64'hFFFF);
      chk("w16_dz", 64'(div_zero16), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width in bits (even, >=8).
REQ-002 SHALL have parameter MUL_LAT, default 2, meaning multiply latency in cycles (1..4).
REQ-003 SHALL have port clk  input  1  clock.
REQ-004 SHALL have port rst  input  1  reset: synchronous, active-high; clock clk.
REQ-005 SHALL have port flush  input  1  abort in-flight operation (exception).
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  block can accept request.
REQ-008 SHALL have port op  input  3  mdu_op_t: MULT, MULTU, MADD, MADDU, MSUB, MSUBU, DIV, DIVU.
REQ-009 SHALL have ports a, b  input  WIDTH  operands (b = divisor).
REQ-010 SHALL have ports hi_in, lo_in  input  WIDTH  accumulator for MADD/MSUB, sampled at accept.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.
REQ-013 SHALL have ports hi, lo  output  WIDTH  result (mul: upper/lower product; div: remainder/quotient).
REQ-014 SHALL have port div_zero  output  1  result came from division by zero; valid with out_valid.

Function
REQ-015 SHALL accept a request on the cycle in_valid && in_ready, latching op, a, b, hi_in, lo_in.
REQ-016 SHALL drive in_ready = 1 only in IDLE; one operation in flight at a time.
REQ-017 SHALL implement FSM IDLE -> MUL (mul ops) or DIV (div ops) on accept; MUL/DIV -> DONE on completion; DONE -> IDLE when out_ready.
REQ-018 SHALL assert out_valid only in DONE and hold hi, lo, div_zero stable until out_ready.
REQ-019 SHALL for multiply take abs values of signed operands, form 2*WIDTH product, negate if signs differ, register through MUL_LAT stages; out_valid first high MUL_LAT+1 cycles after accept.
REQ-020 SHALL for MADD(U)/MSUB(U) produce {hi,lo} = {hi_in,lo_in} +/- product, modulo 2^(2*WIDTH).
REQ-021 SHALL for divide use restoring radix-2 iteration on abs values, one quotient bit per cycle, WIDTH iterations counted by a log2(WIDTH)+1-bit counter; out_valid first high WIDTH+2 cycles after accept (1 setup, WIDTH iterate, 1 sign fix).
REQ-022 SHALL for signed divide negate quotient if a, b signs differ and give remainder the sign of a.
REQ-023 SHALL for b == 0 skip iteration, go to DONE in 2 cycles after accept, lo = all ones, hi = a, div_zero = 1.
REQ-024 SHALL for signed a = min, b = -1 return lo = min, hi = 0, div_zero = 0.
REQ-025 SHALL on flush in any state return to IDLE next cycle, discard result, out_valid = 0; flush has priority over accept and over out_ready in the same cycle.
REQ-026 SHALL allow a new accept in the cycle after DONE is consumed (no back-to-back accept in the DONE cycle).
REQ-027 SHALL treat an undefined op encoding as MULTU.

Reset
REQ-028 SHALL on rst enter IDLE, clear counter and pipeline valids; outputs: in_ready = 1, out_valid = 0, hi = 0, lo = 0, div_zero = 0.
REQ-029 SHALL let rst mid-operation abandon the operation identically to flush.

Structure
REQ-030 SHALL place mdu_op_t, mdu_state_t and default WIDTH/MUL_LAT constants in shared package mdu_pkg.
REQ-031 SHALL implement the iterative divider as one sub-module mdu_div_iter (start, a, b, signed in; done, quotient, remainder, div_zero out); the multiplier stays inline.

Verification
REQ-032 SHALL test MULT a=0xFFFFFFFE, b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA, out_valid 3 cycles after accept.
REQ-033 SHALL test MSUBU hi_in=0, lo_in=5, a=2, b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF.
REQ-034 SHALL test DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, out_valid 34 cycles after accept.
REQ-035 SHALL test DIVU a=10, b=0 -> lo=0xFFFFFFFF, hi=10, div_zero=1 after 2 cycles; DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
REQ-036 SHALL test flush at iteration 10 of DIVU -> next cycle IDLE, in_ready=1, no out_valid; following MULTU 6*7 -> lo=42.
REQ-037 SHALL test out_ready held low 5 cycles in DONE -> hi/lo stable, in_ready=0 throughout; WIDTH=16 build repeats REQ-034 with 18-cycle latency.
